approx_adder_error_monitor32: RTL and testbench

Synthesizable response checker for the 32-bit approximate adders. It is the receiving end of the operand/result stream that drives an adder under test: it takes each operand pair and the adder's result, computes the exact sum, and accumulates error statistics over a programmed window. Error count, mean-error numerator and worst-case error are held for readout. It sits beside any `adders32` block in hardware-in-loop characterization, so approximate adders can be profiled without a simulator `$monitor`.

---
 rtl/approx_adder_pkg.sv | 32 +++
 rtl/abs_err_stage.sv | 52 +++++
 rtl/approx_adder_error_monitor32.sv | 167 ++++++++++++++++
 tb/tb_approx_adder_error_monitor32.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg
//   Shared definitions for the approximate-adder error monitor:
//   default widths, the window-control state type and a saturating
//   accumulate helper.
package approx_adder_pkg;

    localparam int APPROX_WIDTH = 32;
    localparam int APPROX_CNT_W = 16;
    localparam int APPROX_ACC_W = 48;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Adds inc to acc and clamps the result at limit. The sum is formed
    // one bit wider so a carry out of 64 bits can never wrap.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input logic [63:0] limit);
        logic [64:0] total;
        total = {1'b0, acc} + {1'b0, inc};
        if (total > {1'b0, limit}) begin
            sat_add = limit;
        end else begin
            sat_add = total[63:0];
        end
    endfunction

endpackage

// File: rtl/abs_err_stage.sv
// abs_err_stage
//   Registered stage that forms the exact sum of two operands and the
//   absolute difference between that sum and an approximate result.
// Ports:
//   clk           - rising-edge clock
//   rst_n         - synchronous active-low reset
//   in_valid      - operands/result on the inputs are meaningful
//   add1, add2    - WIDTH-bit operands
//   approx_result - WIDTH+1-bit result from the adder under test
//   out_valid     - registered copy of in_valid
//   abs_err       - registered |approx_result - (add1 + add2)|
module abs_err_stage
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = APPROX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    input  logic [WIDTH:0]   approx_result,
    output logic             out_valid,
    output logic [WIDTH:0]   abs_err
);

    logic [WIDTH:0]   exact;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   abs_next;

    // The difference is taken one bit wider than the operands so its top
    // bit is a clean sign. When negative, the magnitude is recomputed the
    // other way round, which always fits in WIDTH+1 bits.
    always_comb begin
        exact    = {1'b0, add1} + {1'b0, add2};
        diff     = {1'b0, approx_result} - {1'b0, exact};
        abs_next = diff[WIDTH+1] ? (exact - approx_result) : diff[WIDTH:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            abs_err   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                abs_err <= abs_next;
            end
        end
    end

endmodule

// File: rtl/approx_adder_error_monitor32.sv
// approx_adder_error_monitor32
//   Receives operand pairs and the matching approximate-adder results,
//   and accumulates error statistics over a window of N samples.
//   Three-stage pipeline: capture (S1), exact sum and abs error (S2),
//   statistics update.
// Ports:
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   start_i, num_samples_i - open a window of N samples (IDLE only)
//   valid_i, ready_o       - sample handshake
//   add1_i, add2_i         - operands applied to the adder under test
//   approx_result_i        - adder-under-test result
//   busy_o                 - window in progress (RUN or DRAIN)
//   done_o                 - one-cycle pulse when statistics are final
//   sample_cnt_o, err_cnt_o, max_abs_err_o, sum_abs_err_o - statistics
module approx_adder_error_monitor32
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = APPROX_WIDTH,
    parameter int CNT_W = APPROX_CNT_W,
    parameter int ACC_W = APPROX_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_result_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH:0]   max_abs_err_o,
    output logic [ACC_W-1:0] sum_abs_err_o
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] n_latched;
    logic [CNT_W-1:0] accepted_cnt;
    logic             start_ok;
    logic             accept;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_add1;
    logic [WIDTH-1:0] s1_add2;
    logic [WIDTH:0]   s1_result;
    logic             s2_valid;
    logic [WIDTH:0]   s2_abs_err;

    assign start_ok = (state == IDLE) && start_i;
    assign accept   = valid_i && ready_o;

    // Next-state and handshake outputs. RUN hands over to DRAIN on the
    // edge of the final acceptance; DRAIN leaves once S1 is empty, so the
    // edge that moves to DONE is the one retiring the last sample.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (num_samples_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                ready_o = (accepted_cnt != n_latched);
                busy_o  = 1'b1;
                if (accept && ((accepted_cnt + CNT_W'(1)) == n_latched)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (!s1_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, window length and acceptance counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            n_latched    <= '0;
            accepted_cnt <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                n_latched    <= num_samples_i;
                accepted_cnt <= '0;
            end else if (accept) begin
                accepted_cnt <= accepted_cnt + CNT_W'(1);
            end
        end
    end

    // S1: capture the accepted sample as presented on the inputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_add1   <= '0;
            s1_add2   <= '0;
            s1_result <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_add1   <= add1_i;
                s1_add2   <= add2_i;
                s1_result <= approx_result_i;
            end
        end
    end

    abs_err_stage #(
        .WIDTH(WIDTH)
    ) u_abs_err_stage (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .in_valid     (s1_valid),
        .add1         (s1_add1),
        .add2         (s1_add2),
        .approx_result(s1_result),
        .out_valid    (s2_valid),
        .abs_err      (s2_abs_err)
    );

    // Statistics: cleared when a window opens, updated once per retiring
    // sample, otherwise held for readout.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sample_cnt_o  <= '0;
            err_cnt_o     <= '0;
            max_abs_err_o <= '0;
            sum_abs_err_o <= '0;
        end else if (start_ok) begin
            sample_cnt_o  <= '0;
            err_cnt_o     <= '0;
            max_abs_err_o <= '0;
            sum_abs_err_o <= '0;
        end else if (s2_valid) begin
            sample_cnt_o <= sample_cnt_o + CNT_W'(1);
            if (s2_abs_err != '0) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
            if (s2_abs_err > max_abs_err_o) begin
                max_abs_err_o <= s2_abs_err;
            end
            sum_abs_err_o <= ACC_W'(sat_add(64'(sum_abs_err_o),
                                            64'(s2_abs_err),
                                            64'(ACC_MAX)));
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor32.sv
// tb_approx_adder_error_monitor32
//   Self-checking bench for approx_adder_error_monitor32 built with a
//   34-bit accumulator so saturation is reachable in a short window.
//   Expected statistics come from a plain arithmetic model of the
//   window: accepted samples are folded into count/error/max/sum.
module tb_approx_adder_error_monitor32;

    localparam int    WIDTH   = 32;
    localparam int    CNT_W   = 16;
    localparam int    ACC_W   = 34;
    localparam longint SAT_MAX = (longint'(1) << ACC_W) - 1;

    localparam int MODE_EXACT    = 0;
    localparam int MODE_SMALL    = 1;
    localparam int MODE_WILD     = 2;
    localparam int MODE_SAT      = 3;
    localparam int MODE_DIRECTED = 4;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] num_samples_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] add1_i = '0;
    logic [WIDTH-1:0] add2_i = '0;
    logic [WIDTH:0]   approx_result_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] sample_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [WIDTH:0]   max_abs_err_o;
    logic [ACC_W-1:0] sum_abs_err_o;

    int checks = 0;
    int passes = 0;

    longint exp_cnt, exp_err, exp_max, exp_sum;
    longint dq_a[$];
    longint dq_b[$];
    longint dq_r[$];

    approx_adder_error_monitor32 #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .num_samples_i  (num_samples_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .add1_i         (add1_i),
        .add2_i         (add2_i),
        .approx_result_i(approx_result_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sample_cnt_o   (sample_cnt_o),
        .err_cnt_o      (err_cnt_o),
        .max_abs_err_o  (max_abs_err_o),
        .sum_abs_err_o  (sum_abs_err_o)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic modelClear();
        exp_cnt = 0;
        exp_err = 0;
        exp_max = 0;
        exp_sum = 0;
    endtask

    // Folds one accepted sample into the expected window statistics.
    task automatic modelAccept(input longint a, input longint b, input longint r);
        longint ex, d;
        ex = a + b;
        d  = r - ex;
        if (d < 0) d = -d;
        exp_cnt++;
        if (d != 0) exp_err++;
        if (d > exp_max) exp_max = d;
        exp_sum = (exp_sum + d > SAT_MAX) ? SAT_MAX : exp_sum + d;
    endtask

    task automatic genSample(input int mode, output longint a, output longint b,
                             output longint r);
        longint ex, e;
        a = longint'($urandom);
        b = longint'($urandom);
        ex = a + b;
        r = ex;
        case (mode)
            MODE_SMALL: begin
                e = longint'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1 && ex >= e) r = ex - e;
                else if (ex + e <= 64'h1_FFFF_FFFF) r = ex + e;
            end
            MODE_WILD: r = {$urandom_range(0, 1), $urandom};
            MODE_SAT: begin
                a = 0;
                b = 0;
                r = 64'h1_FFFF_FFFF;
            end
            MODE_DIRECTED: begin
                if (dq_a.size() > 0) begin
                    a = dq_a.pop_front();
                    b = dq_b.pop_front();
                    r = dq_r.pop_front();
                end
            end
            default: r = ex;
        endcase
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, "_cnt"}, 64'(sample_cnt_o), exp_cnt);
        checkOutput({tag, "_err"}, 64'(err_cnt_o), exp_err);
        checkOutput({tag, "_max"}, 64'(max_abs_err_o), exp_max);
        checkOutput({tag, "_sum"}, 64'(sum_abs_err_o), exp_sum);
    endtask

    // Runs one window of n samples. full_valid keeps valid_i high every
    // cycle; pulse_start raises start_i (with N = 0) once during RUN.
    task automatic applyStimulus(input int n, input int mode, input bit full_valid,
                                 input bit pulse_start, input string tag);
        longint a, b, r;
        int acc;
        int iter;
        @(negedge clk);
        start_i = 1'b1;
        num_samples_i = CNT_W'(n);
        valid_i = 1'b0;
        modelClear();
        @(negedge clk);
        start_i = 1'b0;
        num_samples_i = '0;
        if (n == 0) begin
            checkOutput({tag, "_done"}, 64'(done_o), 1);
            checkOutput({tag, "_busy"}, 64'(busy_o), 0);
            checkOutput({tag, "_ready"}, 64'(ready_o), 0);
            checkStats(tag);
            @(negedge clk);
            checkOutput({tag, "_done_end"}, 64'(done_o), 0);
            return;
        end
        acc = 0;
        iter = 0;
        while (acc < n && iter < 4000) begin
            checkOutput({tag, "_ready"}, 64'(ready_o), 1);
            checkOutput({tag, "_busy"}, 64'(busy_o), 1);
            checkOutput({tag, "_done_run"}, 64'(done_o), 0);
            start_i = pulse_start && (iter == 1);
            valid_i = full_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
            genSample(valid_i ? mode : MODE_WILD, a, b, r);
            add1_i = a[31:0];
            add2_i = b[31:0];
            approx_result_i = r[32:0];
            if (valid_i) begin
                modelAccept(a, b, r);
                acc++;
            end
            iter++;
            @(negedge clk);
        end
        start_i = 1'b0;
        if (acc < n) checkOutput({tag, "_timeout"}, 64'(acc), 64'(n));
        for (int i = 1; i <= 4; i++) begin
            checkOutput({tag, "_ready_drain"}, 64'(ready_o), 0);
            checkOutput({tag, "_done_t"}, 64'(done_o), (i == 3) ? 1 : 0);
            checkOutput({tag, "_busy_t"}, 64'(busy_o), (i < 3) ? 1 : 0);
            if (i >= 3) checkStats(tag);
            valid_i = full_valid ? 1'b1 : 1'(($urandom_range(0, 1)));
            genSample(MODE_WILD, a, b, r);
            add1_i = a[31:0];
            add2_i = b[31:0];
            approx_result_i = r[32:0];
            if (i < 4) @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    initial begin
        $display("[TB] starting");
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        modelClear();
        checkOutput("rst_ready", 64'(ready_o), 0);
        checkOutput("rst_busy", 64'(busy_o), 0);
        checkOutput("rst_done", 64'(done_o), 0);
        checkStats("rst");
        rst_ni = 1'b1;

        // Exact adder, three directed samples.
        dq_a = '{64'h29AF2430, 64'h55555555, 64'hFFFFFFFF};
        dq_b = '{64'h7A1B9ABC, 64'hAAAAAAAA, 64'h00000001};
        dq_r = '{64'h0A3CABEEC, 64'h0FFFFFFFF, 64'h100000000};
        applyStimulus(3, MODE_DIRECTED, 1'b1, 1'b0, "exact3");
        checkOutput("exact3_err_const", 64'(err_cnt_o), 0);
        checkOutput("exact3_sum_const", 64'(sum_abs_err_o), 0);

        // Injected errors: +4 and -0x10.
        dq_a = '{64'h11003456, 64'h8943DEAF};
        dq_b = '{64'h11112323, 64'hDAADBAAD};
        dq_r = '{64'h2211577D, 64'h163F1994C};
        applyStimulus(2, MODE_DIRECTED, 1'b1, 1'b0, "inject2");
        checkOutput("inject2_err_const", 64'(err_cnt_o), 2);
        checkOutput("inject2_max_const", 64'(max_abs_err_o), 64'h10);
        checkOutput("inject2_sum_const", 64'(sum_abs_err_o), 64'h14);

        applyStimulus(2, MODE_EXACT, 1'b1, 1'b0, "backpressure");
        checkOutput("backpressure_cnt_const", 64'(sample_cnt_o), 2);

        applyStimulus(0, MODE_EXACT, 1'b0, 1'b0, "n0");
        applyStimulus(5, MODE_SMALL, 1'b0, 1'b1, "ignstart");

        applyStimulus(4, MODE_SAT, 1'b1, 1'b0, "sat");
        checkOutput("sat_sum_const", 64'(sum_abs_err_o), 64'h3_FFFF_FFFF);

        for (int w = 0; w < 12; w++) begin
            applyStimulus($urandom_range(1, 12), $urandom_range(0, 2),
                          1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        // Reset during RUN after one accepted sample of four.
        @(negedge clk);
        start_i = 1'b1;
        num_samples_i = CNT_W'(4);
        @(negedge clk);
        start_i = 1'b0;
        valid_i = 1'b1;
        add1_i = 32'h0000_1000;
        add2_i = 32'h0000_0001;
        approx_result_i = 33'h0_0000_0F00;
        @(negedge clk);
        valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        modelClear();
        checkOutput("midrst_ready", 64'(ready_o), 0);
        checkOutput("midrst_busy", 64'(busy_o), 0);
        checkOutput("midrst_done", 64'(done_o), 0);
        checkStats("midrst");
        @(negedge clk);
        checkStats("midrst_hold");
        applyStimulus(1, MODE_WILD, 1'b1, 1'b0, "afterrst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
